fm_spi_responder: RTL
=====================

FM_SPI_RESPONDER -- requirements
Module: fm_spi_responder

Interface
REQ-001 Parameter ADDR_W, default 20, memory address width (8 Mbit = 1 MB array).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on CS, SCK and DI_DQ0.
REQ-003 CLK  input  1  system clock; SCK and CS are oversampled on it.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 CS  input  1  chip select, active-low.
REQ-006 SCK  input  1  SPI clock, mode 0, frequency at most CLK/8.
REQ-007 DI_DQ0  input  1  serial data in.
REQ-008 DQ0_O / DQ0_OE  output  1 / 1  DQ0 drive value and enable; used only in dual read.
REQ-009 DO_DQ1  output  1  serial data out.
REQ-010 DQ1_OE  output  1  DO_DQ1 output enable.
REQ-011 mem_addr  output  ADDR_W  array address.
REQ-012 mem_rd  output  1  one-CLK read strobe; mem_rdata is valid the next CLK.
REQ-013 mem_rdata  input  8  read data.
REQ-014 mem_wr / mem_wdata  output  1 / 8  one-CLK write strobe and its data byte.
REQ-015 mem_busy  input  1  array busy; reported as WIP.

Function
REQ-016 After synchronisation, SCK rising edges are detected as one-CLK pulses sck_r and falling edges as sck_f.
REQ-017 DI_DQ0 is sampled on sck_r, MSB first.
REQ-018 Output bits change on sck_f.
REQ-019 FSM states: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, STATUS, IGNORE.
REQ-020 IDLE goes to CMD on CS falling; the first 8 sampled bits form the opcode.
REQ-021 Opcode 06h sets WEL and 04h clears WEL; both take effect at CS rise, and the FSM goes to IGNORE.
REQ-022 Opcode 05h goes to STATUS and shifts out {6'b0, WEL, WIP} repeatedly until CS rises.
REQ-023 Opcodes 03h, 0Bh and 02h go to ADDR and capture 24 bits; mem_addr = addr[ADDR_W-1:0] and higher bits are ignored.
REQ-024 0Bh goes through DUMMY (8 SCK cycles) before RD_DATA.
REQ-025 03h goes directly to RD_DATA.
REQ-026 02h goes to WR_DATA only if WEL=1; otherwise it goes to IGNORE.
REQ-027 Any other opcode goes to IGNORE, which holds all outputs inactive until CS rises.
REQ-028 RD_DATA read path: mem_rd pulses the CLK after the last address/dummy sck_r; the byte is loaded into the shift register before the next sck_f and bit 7 drives DO_DQ1 at that sck_f.
REQ-029 RD_DATA next byte: the following byte is prefetched on bit 1 with mem_addr+1, wrapping at 2^ADDR_W - 1 -> 0.
REQ-030 WR_DATA: each completed byte issues a mem_wr pulse; the address increments in its low 8 bits only (256-byte page wrap).
REQ-031 WR_DATA partial byte: a trailing partial byte at CS rise is discarded.
REQ-032 Writes while mem_busy=1 are dropped, and WEL is still cleared at the end.
REQ-033 WEL is cleared at CS rise after any 02h in which WEL was 1.
REQ-034 CS rise in any state returns the FSM to IDLE within 1 CLK after synchronisation, drops DQ1_OE/DQ0_OE the same CLK, and cancels any partial byte.
REQ-035 sck_r and CS rise in the same CLK: CS rise wins and the bit is discarded.
REQ-036 DQ1_OE is 1 only in RD_DATA and STATUS.

Reset
REQ-037 On RST all outputs are 0: DO_DQ1, DQ1_OE, DQ0_O, DQ0_OE, mem_rd, mem_wr, mem_addr and mem_wdata.
REQ-038 On RST the FSM goes to IDLE and WEL=0.
REQ-039 RST asserted mid-transaction aborts it.
REQ-040 After RST, a transaction is recognised only after CS is next seen high and then falls.

Configuration
REQ-041 Macro FM_DUAL_READ_EN compiled in: opcode 3Bh takes 24 address bits and 8 dummy cycles, then drives 2 bits per sck_f (bit n on DO_DQ1, bit n-1 on DQ0_O) with DQ0_OE=1.
REQ-042 FM_DUAL_READ_EN absent: 3Bh goes to IGNORE, and DQ0_OE and DQ0_O are tied to 0.

Structure
REQ-043 Shared package fm_spi_pkg holds: the opcode constants (03h, 0Bh, 02h, 05h, 06h, 04h, 3Bh), the FSM state enum, DUMMY_CYC=8, and the status bit indices.
REQ-044 One sub-module, fm_spi_sync, holds the synchroniser and edge detector for SCK/CS/DI.

Verification
REQ-045 Send 06h, close, then 05h and read 1 byte -> 02h is returned; with mem_busy=1 the same read returns 03h.
REQ-046 Send 03h with address 0FFFFFh and read 2 bytes -> mem_rd at 0FFFFFh then 00000h, and the shifted bytes equal mem_rdata.
REQ-047 Send 06h, then 02h with address 0000FEh and data A5,5A,C3 -> mem_wr at 0FEh=A5, 0FFh=5A, 000h=C3; a following 05h reads 00h.
REQ-048 Send 02h without a preceding 06h -> no mem_wr.
REQ-049 Raise CS after 13 bits of 0Bh -> no mem_rd, DQ1_OE=0, and the next 05h works normally.
REQ-050 Send 3Bh at address 000010h with 8 dummy cycles and mem_rdata=B4 -> with FM_DUAL_READ_EN, pairs 10,11,01,00 appear on {DO_DQ1,DQ0_O}; without it, both OEs stay 0.

Source files
------------

// File: rtl/fm_spi_pkg.sv
// Shared constants, FSM state type and status-register helpers for the FM SPI responder.
package fm_spi_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_WRDI      = 8'h04;
  localparam logic [7:0] OP_DREAD     = 8'h3B;

  localparam int DUMMY_CYC = 8;
  localparam int STAT_WIP  = 0;
  localparam int STAT_WEL  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s           = '0;
    s[STAT_WEL] = wel;
    s[STAT_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/fm_spi_sync.sv
// Synchroniser chain for CS/SCK/DI plus one-CLK edge pulses on SCK and CS.
module fm_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_sck,
  input  logic i_di,
  output logic o_di,
  output logic o_sck_r,
  output logic o_sck_f,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  // Stages reset to zero so CS looks asserted after reset; a transaction
  // therefore needs a genuine high-then-low on CS before it is recognised.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [2:0] r_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (i_rst) r_q <= '0;
          else       r_q <= {i_cs, i_sck, i_di};
        end
      end else begin : g_next
        always_ff @(posedge i_clk) begin
          if (i_rst) r_q <= '0;
          else       r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  endgenerate

  logic [2:0] w_sync;
  logic       w_cs;
  logic       w_sck;
  logic       r_cs_prev;
  logic       r_sck_prev;

  assign w_sync = g_stage[SYNC_STAGES-1].r_q;
  assign w_cs   = w_sync[2];
  assign w_sck  = w_sync[1];
  assign o_di   = w_sync[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_prev  <= 1'b0;
      r_sck_prev <= 1'b0;
    end else begin
      r_cs_prev  <= w_cs;
      r_sck_prev <= w_sck;
    end
  end

  assign o_sck_r   =  w_sck & ~r_sck_prev;
  assign o_sck_f   = ~w_sck &  r_sck_prev;
  assign o_cs_rise =  w_cs  & ~r_cs_prev;
  assign o_cs_fall = ~w_cs  &  r_cs_prev;

endmodule

// File: rtl/fm_spi_responder.sv
// Oversampled SPI mode-0 memory responder (read/fast read/page program/status/WEL).
// Optional dual-output read (3Bh) is compiled in with `define FM_DUAL_READ_EN.
module fm_spi_responder
  import fm_spi_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCK,
  input  logic              DI_DQ0,
  output logic              DQ0_O,
  output logic              DQ0_OE,
  output logic              DO_DQ1,
  output logic              DQ1_OE,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_busy
);

`ifdef FM_DUAL_READ_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  logic w_di, w_sck_r, w_sck_f, w_cs_rise, w_cs_fall;

  fm_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_cs      (CS),
    .i_sck     (SCK),
    .i_di      (DI_DQ0),
    .o_di      (w_di),
    .o_sck_r   (w_sck_r),
    .o_sck_f   (w_sck_f),
    .o_cs_rise (w_cs_rise),
    .o_cs_fall (w_cs_fall)
  );

  state_t            r_state;
  logic [4:0]        r_bit_cnt;
  logic [2:0]        r_out_cnt;
  logic [6:0]        r_sr_in;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_opcode;
  logic [7:0]        r_sr_out;
  logic [7:0]        r_rd_buf;
  logic [7:0]        r_mem_wdata;
  logic              r_wel, r_wel_set, r_wel_clr;
  logic              r_rd_valid, r_wr_inc, r_dual;
  logic              r_mem_rd, r_mem_wr;
  logic              r_do, r_dq1_oe, r_dq0, r_dq0_oe;

  logic [7:0]        w_byte_in;
  logic [ADDR_W-1:0] w_addr_in;
  logic [7:0]        w_out_src;
  logic [2:0]        w_out_last;
  logic              w_prefetch;

  assign w_byte_in  = {r_sr_in, w_di};
  assign w_addr_in  = {r_addr[ADDR_W-2:0], w_di};
  assign w_out_last = r_dual ? 3'd3 : 3'd7;
  // The next byte is fetched while bit 1 is on the wire, leaving several CLKs before it is needed.
  assign w_prefetch = (r_out_cnt == (r_dual ? 3'd3 : 3'd6));
  assign w_out_src  = (r_out_cnt != 3'd0)     ? r_sr_out :
                      (r_state == ST_STATUS)  ? status_byte(r_wel, mem_busy) : r_rd_buf;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_out_cnt   <= '0;
      r_sr_in     <= '0;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_opcode    <= '0;
      r_sr_out    <= '0;
      r_rd_buf    <= '0;
      r_mem_wdata <= '0;
      r_wel       <= 1'b0;
      r_wel_set   <= 1'b0;
      r_wel_clr   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_wr_inc    <= 1'b0;
      r_dual      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_do        <= 1'b0;
      r_dq1_oe    <= 1'b0;
      r_dq0       <= 1'b0;
      r_dq0_oe    <= 1'b0;
    end else begin
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_rd_valid <= r_mem_rd;
      if (r_rd_valid) r_rd_buf <= mem_rdata;
      if (r_wr_inc) begin
        r_mem_addr[7:0] <= r_mem_addr[7:0] + 8'd1;
        r_wr_inc        <= 1'b0;
      end

      // CS rise outranks any SCK edge seen in the same CLK.
      if (w_cs_rise) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= '0;
        r_out_cnt  <= '0;
        r_rd_valid <= 1'b0;
        r_wr_inc   <= 1'b0;
        r_dual     <= 1'b0;
        r_do       <= 1'b0;
        r_dq1_oe   <= 1'b0;
        r_dq0      <= 1'b0;
        r_dq0_oe   <= 1'b0;
        if (r_wel_set)      r_wel <= 1'b1;
        else if (r_wel_clr) r_wel <= 1'b0;
        r_wel_set  <= 1'b0;
        r_wel_clr  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
              r_out_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (w_sck_r) begin
              r_sr_in   <= w_byte_in[6:0];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_opcode  <= w_byte_in;
                case (w_byte_in)
                  OP_WREN: begin
                    r_wel_set <= 1'b1;
                    r_wel_clr <= 1'b0;
                    r_state   <= ST_IGNORE;
                  end
                  OP_WRDI: begin
                    r_wel_clr <= 1'b1;
                    r_wel_set <= 1'b0;
                    r_state   <= ST_IGNORE;
                  end
                  OP_RDSR: begin
                    r_state  <= ST_STATUS;
                    r_dq1_oe <= 1'b1;
                  end
                  OP_READ, OP_FAST_READ: r_state <= ST_ADDR;
                  OP_PP: begin
                    r_state   <= r_wel ? ST_ADDR : ST_IGNORE;
                    r_wel_clr <= r_wel;
                  end
                  OP_DREAD: r_state <= DUAL_EN ? ST_ADDR : ST_IGNORE;
                  default:  r_state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_r) begin
              r_addr    <= w_addr_in;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt  <= '0;
                r_mem_addr <= w_addr_in;
                if (r_opcode == OP_READ) begin
                  r_state  <= ST_RD_DATA;
                  r_mem_rd <= 1'b1;
                  r_dq1_oe <= 1'b1;
                end else if (r_opcode == OP_PP) begin
                  r_state <= ST_WR_DATA;
                end else begin
                  r_state <= ST_DUMMY;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (w_sck_r) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'(DUMMY_CYC - 1)) begin
                r_bit_cnt <= '0;
                r_state   <= ST_RD_DATA;
                r_mem_rd  <= 1'b1;
                r_dq1_oe  <= 1'b1;
                r_dual    <= DUAL_EN && (r_opcode == OP_DREAD);
                r_dq0_oe  <= DUAL_EN && (r_opcode == OP_DREAD);
              end
            end
          end
          ST_RD_DATA, ST_STATUS: begin
            if (w_sck_f) begin
              r_do <= w_out_src[7];
              if (r_dual) begin
                r_dq0    <= w_out_src[6];
                r_sr_out <= {w_out_src[5:0], 2'b00};
              end else begin
                r_sr_out <= {w_out_src[6:0], 1'b0};
              end
              r_out_cnt <= (r_out_cnt == w_out_last) ? 3'd0 : r_out_cnt + 3'd1;
              if (r_state == ST_RD_DATA && w_prefetch) begin
                r_mem_addr <= r_mem_addr + 1'b1;
                r_mem_rd   <= 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            if (w_sck_r) begin
              r_sr_in   <= w_byte_in[6:0];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_wr_inc  <= 1'b1;
                if (!mem_busy) begin
                  r_mem_wr    <= 1'b1;
                  r_mem_wdata <= w_byte_in;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;
  assign DO_DQ1    = r_do;
  assign DQ1_OE    = r_dq1_oe;
  assign DQ0_O     = DUAL_EN ? r_dq0    : 1'b0;
  assign DQ0_OE    = DUAL_EN ? r_dq0_oe : 1'b0;

endmodule
